// File: rtl/k_alu_seq.sv
// Multi-cycle K ALU with valid/ready handshakes and registered status flags.
// MUL uses shift-add and DIVU/REMU use restoring division, each taking WIDTH iterations.
module k_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             div0
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpSra  = 4'd8;
  localparam logic [3:0] OpSlt  = 4'd9;
  localparam logic [3:0] OpSltu = 4'd10;
  localparam logic [3:0] OpNot  = 4'd11;
  localparam logic [3:0] OpPass = 4'd12;
  localparam logic [3:0] OpMul  = 4'd13;
  localparam logic [3:0] OpDivu = 4'd14;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;     // multiplicand (shifting) or divisor
  logic [WIDTH-1:0] y_q, y_d;     // multiplier (shifting) or dividend/quotient
  logic [WIDTH-1:0] acc_q, acc_d; // product or partial remainder
  logic [WIDTH-1:0] res_q, res_d;
  logic zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d, div0_q, div0_d;

  // Single-cycle datapath on the live inputs, used only at accept
  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpNor:  alu_res = ~(a | b);
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = $unsigned($signed(a) >>> shamt);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OpNot:  alu_res = ~a;
      OpPass: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // Iteration step. With a zero divisor every trial fits, which naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  logic [WIDTH:0]   trial, trial_sub;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, quo_nx, mul_nx;

  assign trial     = {acc_q, y_q[WIDTH-1]};
  assign trial_sub = trial - {1'b0, x_q};
  assign fits      = trial >= {1'b0, x_q};
  assign rem_nx    = fits ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx    = {y_q[WIDTH-2:0], fits};
  assign mul_nx    = acc_q + (y_q[0] ? x_q : '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = sel;
          cnt_d = '0;
          if (sel >= OpMul) begin
            state_d = StBusy;
            acc_d   = '0;
            x_d     = (sel == OpMul) ? a : b;
            y_d     = (sel == OpMul) ? b : a;
          end else begin
            state_d = StDone;
            res_d   = alu_res;
            carry_d = alu_c;
            ovf_d   = alu_v;
            div0_d  = 1'b0;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + SHW'(1);
        if (op_q == OpMul) begin
          acc_d = mul_nx;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else begin
          acc_d = rem_nx;
          y_d   = quo_nx;
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if (op_q == OpMul) begin
            res_d = mul_nx;
          end else begin
            res_d = (op_q == OpDivu) ? quo_nx : rem_nx;
          end
          div0_d = (op_q != OpMul) && (x_q == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    zero_d = (res_d == '0);
    neg_d  = res_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign res       = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

endmodule

// File: doc/k_alu_seq.md
# k_alu_seq

Parametrised, multi-cycle successor to the 32-bit combinational K ALU. It adds WIDTH generalisation, a valid/ready handshake on input and output, and registered status flags. It also adds iterative multiply, unsigned divide and remainder. It sits between operand fetch and writeback and accepts one operation at a time.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept; equals (state==IDLE) && !rst
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (shift amount = b[SHW-1:0])
- sel  input  4  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- res  output  WIDTH  registered result
- zero, neg, carry, ovf, div0  output  1 each  registered flags

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed, res=0/1), 10 SLTU, 11 NOT a, 12 PASS b, 13 MUL (low WIDTH bits of a*b), 14 DIVU, 15 REMU.
- Accept occurs when in_valid && in_ready. a, b and sel are captured at accept; later input changes are ignored until the next accept.
- FSM states:
  - IDLE to DONE on accept of opcodes 0–12.
  - IDLE to BUSY on accept of opcodes 13–15.
  - BUSY to DONE after exactly WIDTH iteration cycles.
  - DONE to IDLE on out_valid && out_ready.
- MUL: shift-add, one bit per cycle from the LSB. Wraps modulo 2^WIDTH.
- DIVU/REMU: restoring division, one quotient bit per cycle from the MSB.
- Divide by zero (b==0 at accept): quotient all ones, remainder = a, div0=1. The op still takes the full WIDTH cycles.
- Flags are computed on the final res and are valid with out_valid:
  - zero: res==0.
  - neg: res[WIDTH-1].
  - carry: ADD carry-out; SUB borrow (a<b unsigned); 0 for all other ops.
  - ovf: signed overflow for ADD/SUB; 0 otherwise.
  - div0: set only for DIVU/REMU with b==0.
- res and flags hold stable while out_valid=1 and out_ready=0.
- There is no overlap between operations: in_ready=0 in BUSY and DONE.

## Timing
- Reset (rst high at a clock edge):
  - State becomes IDLE; out_valid, res and all flags become 0.
  - in_ready reads 0 while rst is high and 1 on the first cycle after.
- Reset mid-BUSY or mid-DONE abandons the operation, and no result is ever presented.
- Single-cycle ops: accept at edge N gives out_valid=1 after edge N+1 (latency 1).
- Multi-cycle ops: accept at edge N gives out_valid=1 after edge N+WIDTH+1.
- out_ready high in DONE: out_valid is high for exactly one cycle. in_ready rises the following cycle, so peak throughput is 1 op per 2 cycles.
- out_ready already high when DONE is entered counts as an immediate handshake.
- in_valid asserted during BUSY/DONE is not accepted. The source must hold it until in_ready.
- rst has priority over every handshake in the same cycle.

## Test plan
- ADD/SUB, WIDTH=32:
  - a=48, b=78, sel=0 → res=126, all flags 0.
  - sel=1 → res=0xFFFFFFE2, neg=1, carry=1, ovf=0. Latency is 1 cycle.
- Overflow and compare:
  - a=0x7FFFFFFF, b=1, ADD → res=0x80000000, ovf=1, neg=1.
  - a=0xFFFFFFFF, b=1, SLT → 1; SLTU → 0.
- Multiply: a=0x00010000, b=0x00010000, MUL → res=0, zero=1. out_valid appears 33 cycles after accept.
- Divide:
  - a=100, b=7 → DIVU 14, REMU 2.
  - b=0 → DIVU 0xFFFFFFFF, REMU 100, div0=1.
  - in_ready stays 0 throughout each operation.
- Backpressure: SRA a=0x80000000, b=4 → res=0xF8000000. With out_ready held low for 5 cycles, res/flags/out_valid stay stable; on release, in_ready rises next cycle.
- Reset mid-op: assert rst on cycle 10 of a DIVU.
  - Next cycle: out_valid=0, res=0, state IDLE.
  - A fresh ADD 2+3 then returns 5 with no stale result.
